// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner select for a shared tristate bus; emits one-hot drive enables with dead turnaround cycles.
// Latency: one edge from a sampled request in IDLE to the registered enable.
// Backpressure: none; the owner keeps the bus while its req is high (bounded by MAX_HOLD when ARB_HOLD_LIMIT_EN is defined).
module tristate_bus_arbiter #(
    parameter int N          = 8,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         sel,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 forced_rel
);

    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t         state;
    logic [W-1:0]   ptr;
    logic [3:0]     turn_cnt;
    logic           win_found;
    logic [W-1:0]   win_idx;

    // Index arithmetic modulo N; N need not be a power of two.
    function automatic logic [W-1:0] wrap(input int s);
        int t;
        t = s;
        if (t >= N) t = t - N;
        return W'(t);
    endfunction

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[wrap(int'(ptr) + i)]) begin
                win_found = 1'b1;
                win_idx   = wrap(int'(ptr) + i);
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt;

    // Arbitration FSM with registered outputs and a per-grant hold limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            turn_cnt   <= '0;
            hold_cnt   <= '0;
            sel        <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            forced_rel <= 1'b0;
        end else begin
            forced_rel <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        sel      <= ONE << win_idx;
                        grant_id <= win_idx;
                        busy     <= 1'b1;
                        ptr      <= wrap(int'(win_idx) + 1);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        sel      <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        turn_cnt <= 4'(TURNAROUND);
                        state    <= TURN;
                    end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
                        // Owner overstayed: take the bus away; the pointer already points past it.
                        sel        <= '0;
                        grant_id   <= '0;
                        busy       <= 1'b0;
                        forced_rel <= 1'b1;
                        turn_cnt   <= 4'(TURNAROUND);
                        state      <= TURN;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURN: begin
                    turn_cnt <= turn_cnt - 4'd1;
                    if (turn_cnt <= 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign forced_rel = 1'b0;

    // Arbitration FSM with registered outputs; ownership is unlimited.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            turn_cnt <= '0;
            sel      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        sel      <= ONE << win_idx;
                        grant_id <= win_idx;
                        busy     <= 1'b1;
                        ptr      <= wrap(int'(win_idx) + 1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // Other requests are ignored until the owner lets go.
                    if (!req[grant_id]) begin
                        sel      <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        turn_cnt <= 4'(TURNAROUND);
                        state    <= TURN;
                    end
                end
                TURN: begin
                    // Bus stays undriven for TURNAROUND cycles; no arbitration here.
                    turn_cnt <= turn_cnt - 4'd1;
                    if (turn_cnt <= 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that generates the one-hot tristate drive enables (sel) for a shared single-wire or multi-bit bus with N drivers.
- It is the controlling end of the one-hot-select tristate mux: its sel output connects directly to the mux's enable inputs.
- It guarantees at most one enable is active at any time, and inserts dead (all-Z) turnaround cycles between owners so two drivers never contend.

Parameters:
- N, 8, number of requesters/drivers (2..16).
- TURNAROUND, 1, all-zero sel cycles inserted after a release (1..15).
- MAX_HOLD, 16, grant cycle limit when ARB_HOLD_LIMIT_EN is defined (2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request level per driver; held high for as long as the driver wants the bus.
- sel  output  N  registered one-hot tristate enable, or all-zero.
- grant_id  output  $clog2(N)  binary index of the current owner; 0 when there is no owner.
- busy  output  1  high when sel is nonzero.
- forced_rel  output  1  one-cycle pulse on a timeout release (tied 0 when the feature is off).

Behaviour:
- All outputs are registered. Reset is synchronous and active-high, and is sampled only on the rising edge of clk.
- Reset values: sel=0, grant_id=0, busy=0, forced_rel=0, state=IDLE, rr pointer=0, turnaround counter=0.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0 at edge k, choose the winner by searching from index ptr upward, wrapping modulo N.
  - At edge k: sel=onehot(winner), grant_id=winner, busy=1, ptr=(winner+1) mod N, go to GRANT.
  - Latency is one edge from the first req sample to the enable.
- GRANT:
  - Ownership holds while req[grant_id]=1; other requests are ignored, with no preemption.
  - When req[grant_id]=0 at edge k: sel=0, busy=0, load the counter with TURNAROUND, go to TURN.
- TURN:
  - The counter decrements each edge.
  - When the counter reaches 1, go to IDLE at that edge. The bus is therefore all-Z for exactly TURNAROUND cycles.
  - Requests are not evaluated in TURN. Arbitration resumes in IDLE, so the minimum gap between two owners' enables is TURNAROUND+1 cycles.
- Fairness: the pointer advances past each winner, so with all requests asserted the grant order is 0,1,2,...,N-1,0.
- Simultaneous events:
  - A release and a new request in the same cycle: the release is processed and the new request waits for IDLE.
  - rst high in any state, including mid-grant, gives sel=0 at that edge and ptr=0.
- Invariants, each checked every cycle:
  - popcount(sel) <= 1.
  - busy == (sel != 0).
  - grant_id matches the index of the set bit in sel.
- A req pulse shorter than one cycle that is not sampled at an edge is never seen.
- A requester that deasserts before it is granted is simply not chosen.
- Unused req bits beyond N do not exist; there is no X propagation from undefined reqs (treat X as 0 only in simulation checks).

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- When defined:
  - A hold counter resets to 0 on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 while req[grant_id] is still 1, the next edge forces sel=0 and busy=0, pulses forced_rel=1 for one cycle, and goes to TURN.
  - The pointer has already moved past the owner, so the timed-out driver re-arbitrates normally.
  - Net effect: the enable is active for at most MAX_HOLD cycles.
- When undefined:
  - No hold counter exists, forced_rel is constant 0, and ownership is unlimited.

Test Plan:
- Reset, then req=8'b0000_0100 at cycle 2 -> sel=8'b0000_0100, grant_id=2, busy=1 after that edge; rst pulse at cycle 6 -> sel=0 and ptr=0 at the next edge.
- req=8'hFF held, each owner holds 3 cycles then drops its bit for one cycle, TURNAROUND=1 -> grant order 0..7,0 with exactly one all-zero cycle plus one IDLE cycle between consecutive grants.
- Owner 3 granted, req[3] falls while req[5] rises in the same cycle -> sel=0 for TURNAROUND=1 cycle, IDLE for 1 cycle, then sel=8'b0010_0000.
- Random req over 10k cycles -> popcount(sel)<=1 on every cycle, no grant given to a non-requesting index, and no starvation (each continuously requesting index is granted within N grants).
- With ARB_HOLD_LIMIT_EN and MAX_HOLD=4, req[1] held high -> sel[1] high exactly 4 cycles, forced_rel=1 for one cycle, then a TURN cycle, then regrant to 1 if it is the only requester.
- TURNAROUND=3, owner 0 releases -> sel=0 for exactly 3 cycles in TURN before the IDLE arbitration cycle.
